// File: rtl/lcd_glyph_spi.sv
// Wishbone slave that streams font-ROM glyphs, cursor positions and raw commands to a
// PCD8544-style SPI LCD. Optional inversion register at 0x10: define LCD_GLYPH_INVERT_EN.
module lcd_glyph_spi #(
  parameter int CLK_DIV     = 4,  // clk cycles per SCK half-period, >= 1
  parameter int GLYPH_BYTES = 8   // column bytes per glyph, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [9:0]  font_addr,
  output logic        font_rd,
  input  logic [7:0]  font_data,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        lcd_dc,
  output logic        lcd_cs_n,
  output logic [2:0]  dbg_state
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [1:0] SRC_ROM = 2'd0;
  localparam logic [1:0] SRC_POS = 2'd1;
  localparam logic [1:0] SRC_CMD = 2'd2;
  localparam int COL_W = (GLYPH_BYTES > 1) ? $clog2(GLYPH_BYTES) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [2:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [9:0]       font_addr_q, font_addr_d;
  logic             font_rd_q, font_rd_d;
  logic             sck_q, sck_d, mosi_q, mosi_d, dc_q, dc_d, cs_n_q, cs_n_d;
  logic             overrun_q, overrun_d;
  logic [1:0]       src_q, src_d;
  logic [7:0]       b0_q, b0_d, b1_q, b1_d, sh_q, sh_d;
  logic [COL_W-1:0] col_q, col_d, col_inc;
  logic             second_q, second_d, lcnt_q, lcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
`ifdef LCD_GLYPH_INVERT_EN
  logic             invert_q, invert_d;
`endif

  logic       req, free, div_last, more, job_sel;
  logic [2:0] adr_idx;
  logic [6:0] x_clamp;
  logic [2:0] bank_clamp;
  logic [7:0] rom_byte, load_byte;
  logic       unused_ok;

  // Handshake: a request is taken when stb&cyc and ack_q is low; ack_q then pulses for
  // exactly one clk and gates wb_ack_o, so every request sees one ack and is never re-taken.
  assign req        = wb_stb_i & wb_cyc_i & ~ack_q;
  assign adr_idx    = wb_adr_i[4:2];
  assign job_sel    = (adr_idx == 3'd0) || (adr_idx == 3'd1) || (adr_idx == 3'd3);
  assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));
  // The last DONE clk counts as free so a back-to-back job is not flagged as overrun.
  assign free       = (state_q == S_IDLE) || ((state_q == S_DONE) && div_last);
  assign col_inc    = col_q + 1'b1;
  assign more       = ((src_q == SRC_ROM) && (col_q != COL_W'(GLYPH_BYTES - 1))) ||
                      ((src_q == SRC_POS) && !second_q);
  assign x_clamp    = (wb_dat_i[6:0] > 7'd83) ? 7'd83 : wb_dat_i[6:0];
  assign bank_clamp = (wb_dat_i[10:8] > 3'd5) ? 3'd5 : wb_dat_i[10:8];
`ifdef LCD_GLYPH_INVERT_EN
  assign rom_byte   = font_data ^ {8{invert_q}};
`else
  assign rom_byte   = font_data;
`endif
  assign load_byte  = (src_q == SRC_ROM) ? rom_byte : (second_q ? b1_q : b0_q);
  assign unused_ok  = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:11]};

  always_comb begin
    state_d = state_q;  ack_d = req;  dat_d = dat_q;
    font_addr_d = font_addr_q;  font_rd_d = font_rd_q;
    sck_d = sck_q;  mosi_d = mosi_q;  dc_d = dc_q;  cs_n_d = cs_n_q;
    overrun_d = overrun_q;  src_d = src_q;  b0_d = b0_q;  b1_d = b1_q;  sh_d = sh_q;
    col_d = col_q;  second_d = second_q;  lcnt_d = lcnt_q;  div_d = div_q;  bit_d = bit_q;
`ifdef LCD_GLYPH_INVERT_EN
    invert_d = invert_q;
`endif
    case (state_q)
      S_IDLE: begin
        sck_d  = 1'b0;
        cs_n_d = 1'b1;
      end
      S_LOAD: begin
        // First clk: ROM read pulse and chip select; second clk: byte is ready.
        font_rd_d = 1'b0;
        cs_n_d    = 1'b0;
        lcnt_d    = 1'b1;
        if (lcnt_q) begin
          sh_d    = load_byte;
          mosi_d  = load_byte[7];
          div_d   = '0;
          bit_d   = 3'd0;
          lcnt_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = more ? S_NEXT : S_DONE;
              if (!more) cs_n_d = 1'b1;
            end else begin
              bit_d  = bit_q + 1'b1;
              sh_d   = {sh_q[6:0], 1'b0};
              mosi_d = sh_q[6];
            end
          end
        end
      end
      S_NEXT: begin
        if (src_q == SRC_ROM) begin
          col_d       = col_inc;
          font_rd_d   = 1'b1;
          font_addr_d = 10'({b0_q[6:0], col_inc});
        end else begin
          second_d = 1'b1;
        end
        lcnt_d  = 1'b0;
        state_d = S_LOAD;
      end
      S_DONE: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (req) begin
      dat_d = '0;
      if (wb_we_i) begin
        if (job_sel) begin
          if (free) begin
            src_d    = (adr_idx == 3'd0) ? SRC_ROM : (adr_idx == 3'd1) ? SRC_POS : SRC_CMD;
            b0_d     = (adr_idx == 3'd0) ? {1'b0, wb_dat_i[6:0]} :
                       (adr_idx == 3'd1) ? {1'b1, x_clamp} : wb_dat_i[7:0];
            b1_d     = {5'b01000, bank_clamp};
            dc_d     = (adr_idx == 3'd0);
            font_rd_d = (adr_idx == 3'd0);
            if (adr_idx == 3'd0) font_addr_d = 10'({wb_dat_i[6:0], {COL_W{1'b0}}});
            col_d    = '0;
            second_d = 1'b0;
            lcnt_d   = 1'b0;
            div_d    = '0;
            sck_d    = 1'b0;
            state_d  = S_LOAD;
          end else begin
            overrun_d = 1'b1;
          end
        end
`ifdef LCD_GLYPH_INVERT_EN
        if (adr_idx == 3'd4) invert_d = wb_dat_i[0];
`endif
      end else begin
        if (adr_idx == 3'd2) begin
          dat_d     = {30'd0, overrun_q, ~free};
          overrun_d = 1'b0;
        end
`ifdef LCD_GLYPH_INVERT_EN
        if (adr_idx == 3'd4) dat_d = {31'd0, invert_q};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  ack_q <= 1'b0;  dat_q <= '0;
      font_addr_q <= '0;  font_rd_q <= 1'b0;
      sck_q <= 1'b0;  mosi_q <= 1'b0;  dc_q <= 1'b0;  cs_n_q <= 1'b1;
      overrun_q <= 1'b0;  src_q <= SRC_ROM;  b0_q <= '0;  b1_q <= '0;  sh_q <= '0;
      col_q <= '0;  second_q <= 1'b0;  lcnt_q <= 1'b0;  div_q <= '0;  bit_q <= '0;
`ifdef LCD_GLYPH_INVERT_EN
      invert_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  ack_q <= ack_d;  dat_q <= dat_d;
      font_addr_q <= font_addr_d;  font_rd_q <= font_rd_d;
      sck_q <= sck_d;  mosi_q <= mosi_d;  dc_q <= dc_d;  cs_n_q <= cs_n_d;
      overrun_q <= overrun_d;  src_q <= src_d;  b0_q <= b0_d;  b1_q <= b1_d;  sh_q <= sh_d;
      col_q <= col_d;  second_q <= second_d;  lcnt_q <= lcnt_d;  div_q <= div_d;  bit_q <= bit_d;
`ifdef LCD_GLYPH_INVERT_EN
      invert_q <= invert_d;
`endif
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = wb_stb_i & wb_cyc_i & ack_q;
  assign font_addr = font_addr_q;
  assign font_rd   = font_rd_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign lcd_dc    = dc_q;
  assign lcd_cs_n  = cs_n_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_lcd_glyph_spi.sv
// Directed bench for lcd_glyph_spi: table of register writes with hand-computed SPI bytes,
// plus sequences for busy/overrun, back-to-back at DONE, inversion and mid-job reset.
module tb_lcd_glyph_spi;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, font_rd, spi_sck, spi_mosi, lcd_dc, lcd_cs_n;
  logic [9:0]  font_addr;
  logic [7:0]  font_data = '0;
  logic [2:0]  dbg_state;

  lcd_glyph_spi #(.CLK_DIV(CLK_DIV), .GLYPH_BYTES(8)) dut (
    .clk(clk), .reset(reset), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(4'hF), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .font_addr(font_addr), .font_rd(font_rd), .font_data(font_data),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- font ROM model ----------------
  logic [7:0] rom [0:1023];
  always @(posedge clk) if (font_rd) font_data <= rom[font_addr];

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];      // {dc, byte}
  logic [9:0] addr_q[$];
  int checks = 0, errors = 0;
  int cs_falls = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_glyph(input logic [6:0] ch, input logic inv);
    for (int c = 0; c < 8; c++) begin
      exp_q.push_back({1'b1, rom[{ch, 3'(c)}] ^ {8{inv}}});
      addr_q.push_back({ch, 3'(c)});
    end
  endtask

  // SPI / ROM-port monitor, sampled on the falling clk edge
  initial begin
    int cyc, last_rise, nbit;
    logic sck_prev, cs_prev, dc0, ok;
    logic [7:0] sh;
    logic [8:0] e;
    cyc = 0; last_rise = 0; nbit = 0; sck_prev = 0; cs_prev = 1; dc0 = 0; ok = 1; sh = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        nbit = 0; sck_prev = 0; cs_prev = 1;
      end else begin
        if (cs_prev && !lcd_cs_n) cs_falls++;
        cs_prev = lcd_cs_n;
        if (font_rd) begin
          if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL font_rd_unexpected got_addr=%h", font_addr);
          end else chk("font_addr", 32'(font_addr), 32'(addr_q.pop_front()));
        end
        if (spi_sck && !sck_prev) begin
          if (nbit == 0) begin dc0 = lcd_dc; ok = 1; end
          else if (cyc - last_rise != 2 * CLK_DIV) ok = 0;
          if (lcd_cs_n || lcd_dc !== dc0) ok = 0;
          last_rise = cyc;
          sh = {sh[6:0], spi_mosi};
          nbit++;
          if (nbit == 8) begin
            nbit = 0;
            chk("byte_timing_cs_dc", 32'(ok), 32'd1);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL spi_byte_unexpected got=%h exp=none", {dc0, sh});
            end else begin
              e = exp_q.pop_front();
              chk("spi_byte", 32'({dc0, sh}), 32'(e));
            end
          end
        end
        sck_prev = spi_sck;
      end
    end
  end

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic wb_cycle(input logic we, input logic [7:0] adr, input logic [31:0] data,
                          output logic [31:0] rdata);
    logic got;
    got = 0; rdata = '0;
    wb_stb = 1; wb_cyc = 1; wb_we = we; wb_adr = {24'd0, adr}; wb_dat_i = data;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1; rdata = wb_dat_o; end
    end
    @(negedge clk);
    wb_stb = 0; wb_cyc = 0; wb_we = 0;
    chk("wb_ack", 32'(got), 32'd1);
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] data);
    logic [31:0] d;
    wb_cycle(1'b1, adr, data, d);
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    logic done;
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      wb_cycle(1'b0, 8'h08, 32'd0, d);
      if (!d[0]) done = 1;
    end
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_cs(input logic level);
    logic seen;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (lcd_cs_n === level) seen = 1;
    end
    chk("cs_wait_timeout", 32'(seen), 32'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  adr;
    logic [31:0] data;
    int          nb;   // 0, 1, 2 bytes from e0/e1; 8 = glyph from ROM
    logic [8:0]  e0;
    logic [8:0]  e1;
  } vec_t;
  vec_t vecs [12];

  initial begin
    logic [31:0] d;
    int wd;
    for (int a = 0; a < 1024; a++) rom[a] = 8'(a * 37 + 11);
    vecs[0]  = '{8'h0C, 32'h0000_0021, 1, {1'b0, 8'h21}, 9'h0};
    vecs[1]  = '{8'h0C, 32'hFFFF_FFA5, 1, {1'b0, 8'hA5}, 9'h0};
    vecs[2]  = '{8'h04, 32'h0000_075A, 2, {1'b0, 8'hD3}, {1'b0, 8'h45}};
    vecs[3]  = '{8'h04, 32'h0000_0000, 2, {1'b0, 8'h80}, {1'b0, 8'h40}};
    vecs[4]  = '{8'h04, 32'h0000_030A, 2, {1'b0, 8'h8A}, {1'b0, 8'h43}};
    vecs[5]  = '{8'h04, 32'h0000_0553, 2, {1'b0, 8'hD3}, {1'b0, 8'h45}};
    vecs[6]  = '{8'h04, 32'h0000_0654, 2, {1'b0, 8'hD3}, {1'b0, 8'h45}};
    vecs[7]  = '{8'h00, 32'h0000_0041, 8, 9'h0, 9'h0};
    vecs[8]  = '{8'h00, 32'h0000_00C1, 8, 9'h0, 9'h0};
    vecs[9]  = '{8'h00, 32'h0000_0000, 8, 9'h0, 9'h0};
    vecs[10] = '{8'h00, 32'h0000_007F, 8, 9'h0, 9'h0};
    vecs[11] = '{8'h18, 32'h0000_0021, 0, 9'h0, 9'h0};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_dc", 32'(lcd_dc), 32'd0);
    chk("rst_font_rd", 32'(font_rd), 32'd0);
    chk("rst_font_addr", 32'(font_addr), 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    reset = 0;
    @(negedge clk);
    wb_cycle(1'b0, 8'h08, 32'd0, d);
    chk("rst_stat", d, 32'd0);

    // table-driven jobs
    for (int v = 0; v < 12; v++) begin
      cs_falls = 0;
      if (vecs[v].nb == 8) push_glyph(vecs[v].data[6:0], 1'b0);
      if (vecs[v].nb == 1 || vecs[v].nb == 2) exp_q.push_back(vecs[v].e0);
      if (vecs[v].nb == 2) exp_q.push_back(vecs[v].e1);
      wb_write(vecs[v].adr, vecs[v].data);
      wait_idle();
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("cs_windows", 32'(cs_falls), (vecs[v].nb > 0) ? 32'd1 : 32'd0);
      chk("cs_high_after", 32'(lcd_cs_n), 32'd1);
    end

    // unmapped read
    wb_cycle(1'b0, 8'h14, 32'd0, d);
    chk("unmapped_read", d, 32'd0);

    // writes while busy: acked, dropped, overrun set then cleared by read
    push_glyph(7'h20, 1'b0);
    wb_write(8'h00, 32'h20);
    wb_cycle(1'b0, 8'h08, 32'd0, d);
    chk("stat_busy", d, 32'h1);
    wb_write(8'h00, 32'h55);
    wb_write(8'h0C, 32'h99);
    wb_cycle(1'b0, 8'h08, 32'd0, d);
    chk("stat_overrun", d, 32'h3);
    wb_cycle(1'b0, 8'h08, 32'd0, d);
    chk("stat_overrun_cleared", d, 32'h1);
    wait_idle();
    chk("busy_exp_drained", 32'(exp_q.size()), 32'd0);

    // request landing on the last DONE clk starts a new job without overrun
    exp_q.push_back({1'b0, 8'h21});
    wb_write(8'h0C, 32'h21);
    wait_cs(1'b0);
    wait_cs(1'b1);
    repeat (3) @(negedge clk);
    exp_q.push_back({1'b0, 8'h3C});
    wb_write(8'h0C, 32'h3C);
    wait_idle();
    wb_cycle(1'b0, 8'h08, 32'd0, d);
    chk("done_boundary_stat", d, 32'h0);
    chk("done_boundary_drained", 32'(exp_q.size()), 32'd0);

    // inversion register
    for (int c = 0; c < 8; c++) rom[{7'h10, 3'(c)}] = 8'h7E;
    wb_write(8'h10, 32'h1);
    wb_cycle(1'b0, 8'h10, 32'd0, d);
`ifdef LCD_GLYPH_INVERT_EN
    chk("invert_readback", d, 32'h1);
    push_glyph(7'h10, 1'b1);
`else
    chk("invert_absent", d, 32'h0);
    push_glyph(7'h10, 1'b0);
`endif
    wb_write(8'h00, 32'h10);
    wait_idle();
    exp_q.push_back({1'b0, 8'h21});
    wb_write(8'h0C, 32'h21);
    wait_idle();
    chk("invert_drained", 32'(exp_q.size()), 32'd0);
    wb_write(8'h10, 32'h0);

    // reset in the middle of a glyph
    push_glyph(7'h41, 1'b0);
    wb_write(8'h00, 32'h41);
    repeat (100) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("midrst_sck", 32'(spi_sck), 32'd0);
    chk("midrst_font_rd", 32'(font_rd), 32'd0);
    chk("midrst_dc", 32'(lcd_dc), 32'd0);
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    wb_cycle(1'b0, 8'h08, 32'd0, d);
    chk("midrst_stat", d, 32'h0);
    wd = 0;
    repeat (200) begin
      @(negedge clk);
      if (!lcd_cs_n) wd++;
    end
    chk("midrst_quiet", 32'(wd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
